l1c_inst_assoc: RTL and testbench
=================================

// Module: l1c_inst_assoc
// PURPOSE
// - Parametrised read-only L1 instruction cache between the CPU core fetch port and the CPU wrapper / AXI master.
// - Supports direct-mapped or 2-way set-associative operation, configurable sets and line length, and pseudo-LRU replacement.
// - Has a whole-cache invalidate (flush) input. Tag, valid and data storage are internal flop arrays; no SRAM wrapper.
// PARAMETERS
// - ADDR_W      32  byte-address width
// - DATA_W      32  word width; a word is 4 bytes, so byte offset = 2 bits
// - SETS        64  number of sets; power of 2, >=2; IDX_W = log2(SETS)
// - LINE_WORDS  4   words per line; power of 2, >=2; OFF_W = log2(LINE_WORDS)
// - WAYS        2   associativity; legal values 1 or 2
// - Derived: TAG_W = ADDR_W-IDX_W-OFF_W-2
// - Address split: tag = addr[ADDR_W-1 -: TAG_W], idx = addr[OFF_W+2 +: IDX_W], word = addr[2 +: OFF_W]
// PORTS
// - clk        in   1       clock; all state updates on rising edge
// - rst_n      in   1       asynchronous, active-low reset
// - core_addr  in   ADDR_W  fetch byte address; sampled in IDLE when core_req=1
// - core_req   in   1       fetch request
// - flush      in   1       single-cycle pulse: invalidate all lines
// - core_out   out  DATA_W  fetched word; valid while core_wait=0 in DONE
// - core_wait  out  1       core stall
// - I_out      in   DATA_W  memory read data; valid on a beat cycle
// - I_wait     in   1       memory busy; a beat completes when I_rreq=1 && I_wait=0
// - I_rreq     out  1       memory read request, one word per beat
// - I_addr     out  ADDR_W  word address of the current beat
// - I_type     out  3       constant `CACHE_WORD
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; all valid bits=0; all LRU bits=0; beat cnt=0; flush_pend=0.
//   Outputs at reset: core_out=0, core_wait=0, I_rreq=0, I_addr=0.
//   Reset asserted mid-refill abandons the refill immediately; no partial line becomes valid.
// - States: IDLE, FLUSH, LOOKUP, REFILL, DONE.
// - IDLE transitions:
//   - if flush_pend or flush -> FLUSH
//   - else if core_req -> LOOKUP, latching core_addr
// - FLUSH: clears all valid and LRU bits in one cycle -> IDLE.
// - LOOKUP: compares tags of all ways at the latched index.
//   - Hit -> DONE: core_out <= hit word; LRU[idx] <= other way.
//   - Miss -> REFILL with cnt=0.
// - REFILL:
//   - I_rreq=1; I_addr = {tag,idx,cnt,2'b00}.
//   - On each beat, I_out is stored as word cnt of the line buffer and cnt increments.
//   - While I_wait=1: I_addr, cnt and the line buffer hold.
//   - I_rreq drops in the cycle after the beat with cnt=LINE_WORDS-1.
//   - After the last beat:
//     - victim way = first invalid way (way0 first), else LRU[idx]; WAYS=1 -> way0
//     - write tag and line, set valid; LRU[idx] <= other way
//     - core_out <= requested word -> DONE
// - DONE: core_wait=0 for exactly one cycle -> IDLE.
// - core_wait:
//   - IDLE: core_wait = core_req || flush_pend || flush
//   - FLUSH, LOOKUP, REFILL: core_wait = 1
//   - DONE: core_wait = 0
// - Latency: hit = request cycle + 2 (data in DONE); miss = 2 + LINE_WORDS beats + memory stall cycles.
// - Back-to-back requests: core_req high in DONE is ignored; it is accepted next cycle in IDLE.
// - Flush in a non-IDLE state: sets flush_pend; the current access completes with its data; FLUSH runs before the next lookup.
// - core_out holds its last value outside DONE. WAYS=1 ignores LRU entirely.
// CONFIGURATION
// - L1CI_PERF_EN defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0].
//   - Counters reset to 0 on reset, saturate at 32'hFFFF_FFFF, and are not cleared by flush.
//   - hit_cnt +1 on each LOOKUP hit; miss_cnt +1 on each LOOKUP miss.
// - L1CI_PERF_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING (SETS=64, LINE_WORDS=4, WAYS=2; 0x104 / 0x504 / 0x904 all map to idx 0x10)
// - Cold miss 0x104, I_out=A0..A3 -> beats at I_addr 0x100,104,108,10C; core_out=A1; core_wait=0 for 1 cycle.
// - Then fetch 0x108 -> hit; core_wait=0 two cycles after req; core_out=A2; I_rreq never asserted.
// - Fill 0x504, then fetch 0x904 -> evicts the 0x104 line (LRU); then 0x104 misses and 0x504 hits.
// - I_wait=1 for 3 cycles on each beat -> I_addr/cnt stable while stalled; miss latency = 2+4+12 cycles.
// - flush pulse during REFILL of 0x104 -> response A1 delivered, FLUSH follows; next 0x104 misses.
// - rst_n=0 during beat 2 -> I_rreq=0, core_wait=0 at once; after release, 0x104 misses (perf: miss_cnt=1).

Source files
------------

// File: rtl/l1c_inst_assoc_if.sv
// Fetch-side and memory-side bus bundle for the L1 instruction cache.
// The slave modport is the cache view; the master modport is the core/memory view.
interface l1c_inst_assoc_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] core_addr;
  logic              core_req;
  logic [DATA_W-1:0] core_out;
  logic              core_wait;
  logic [DATA_W-1:0] I_out;
  logic              I_wait;
  logic              I_rreq;
  logic [ADDR_W-1:0] I_addr;
  logic [2:0]        I_type;

  modport slave (
    input  core_addr, core_req, I_out, I_wait,
    output core_out, core_wait, I_rreq, I_addr, I_type
  );

  modport master (
    output core_addr, core_req, I_out, I_wait,
    input  core_out, core_wait, I_rreq, I_addr, I_type
  );
endinterface

// File: rtl/l1c_inst_assoc.sv
// Read-only L1 instruction cache, direct-mapped or 2-way with pseudo-LRU.
// Whole-cache flush input; storage is internal flop arrays.
// Optional macro L1CI_PERF_EN adds saturating hit_cnt / miss_cnt outputs.
`ifndef CACHE_WORD
`define CACHE_WORD 3'b010
`endif

module l1c_inst_assoc #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int WAYS       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  l1c_inst_assoc_if.slave       bus
`ifdef L1CI_PERF_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_LOOKUP = 3'd2,
    S_REFILL = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [OFF_W-1:0]    cnt_q, cnt_d;
  logic                rreq_q, rreq_d;
  logic [DATA_W-1:0]   core_out_q, core_out_d;
  logic                flush_pend_q, flush_pend_d;
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     valid_d [SETS];
  logic [SETS-1:0]     lru_q, lru_d;
  logic [DATA_W-1:0]   lbuf_q [LINE_WORDS];
  logic [DATA_W-1:0]   lbuf_d [LINE_WORDS];

  // Tag and data storage carry no reset; valid bits gate every use.
  logic [TAG_W-1:0]    tag_q  [WAYS][SETS];
  logic [DATA_W-1:0]   data_q [WAYS][SETS][LINE_WORDS];

  logic [TAG_W-1:0]    tag_s;
  logic [IDX_W-1:0]    idx_s;
  logic [OFF_W-1:0]    word_s;
  logic                hit_s;
  logic [WAY_W-1:0]    hit_way_s;
  logic [DATA_W-1:0]   hit_word_s;
  logic [WAY_W-1:0]    victim_s;
  logic [DATA_W-1:0]   fill_line_s [LINE_WORDS];
  logic                fill_we_s;
  logic                core_wait_s;
  logic                unused_s;

  assign tag_s  = addr_q[ADDR_W-1 -: TAG_W];
  assign idx_s  = addr_q[OFF_W+2 +: IDX_W];
  assign word_s = addr_q[2 +: OFF_W];

  // Byte-offset bits are irrelevant to a word-organised cache.
  assign unused_s = ^addr_q[1:0];

  // Tag compare across all ways at the latched index.
  always_comb begin
    hit_s      = 1'b0;
    hit_way_s  = {WAY_W{1'b0}};
    hit_word_s = {DATA_W{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_s][WAY_W'(w)] && (tag_q[WAY_W'(w)][idx_s] == tag_s)) begin
        hit_s      = 1'b1;
        hit_way_s  = WAY_W'(w);
        hit_word_s = data_q[WAY_W'(w)][idx_s][word_s];
      end else begin
        hit_s      = hit_s;
      end
    end
  end

  // Victim choice: lowest invalid way, otherwise the LRU way; single way always way 0.
  always_comb begin
    victim_s = (WAYS > 1) ? WAY_W'(lru_q[idx_s]) : {WAY_W{1'b0}};
    for (int w = WAYS - 1; w >= 0; w--) begin
      victim_s = valid_q[idx_s][WAY_W'(w)] ? victim_s : WAY_W'(w);
    end
  end

  // Completed line: buffered beats plus the beat arriving this cycle.
  always_comb begin
    for (int i = 0; i < LINE_WORDS; i++) begin
      fill_line_s[i] = (OFF_W'(i) == cnt_q) ? bus.I_out : lbuf_q[i];
    end
  end

  // Next-state and datapath updates of the controller.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    rreq_d       = rreq_q;
    core_out_d   = core_out_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    lru_d        = lru_q;
    lbuf_d       = lbuf_q;
    fill_we_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush_pend_q || flush) begin
          state_d = S_FLUSH;
        end else if (bus.core_req) begin
          state_d = S_LOOKUP;
          addr_d  = bus.core_addr;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        for (int s = 0; s < SETS; s++) begin
          valid_d[s] = {WAYS{1'b0}};
        end
        lru_d        = {SETS{1'b0}};
        flush_pend_d = flush;
        state_d      = S_IDLE;
      end
      S_LOOKUP: begin
        flush_pend_d = flush_pend_q | flush;
        if (hit_s) begin
          core_out_d = hit_word_s;
          if (WAYS > 1) begin
            lru_d[idx_s] = ~hit_way_s[0];
          end else begin
            lru_d = lru_q;
          end
          state_d = S_DONE;
        end else begin
          cnt_d   = {OFF_W{1'b0}};
          rreq_d  = 1'b1;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        flush_pend_d = flush_pend_q | flush;
        if (!bus.I_wait) begin
          lbuf_d[cnt_q] = bus.I_out;
          if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
            fill_we_s                = 1'b1;
            valid_d[idx_s][victim_s] = 1'b1;
            if (WAYS > 1) begin
              lru_d[idx_s] = ~victim_s[0];
            end else begin
              lru_d = lru_q;
            end
            core_out_d = fill_line_s[word_s];
            rreq_d     = 1'b0;
            cnt_d      = {OFF_W{1'b0}};
            state_d    = S_DONE;
          end else begin
            cnt_d = cnt_q + OFF_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_DONE: begin
        flush_pend_d = flush_pend_q | flush;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controller, valid and LRU state; reset abandons any refill in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= {ADDR_W{1'b0}};
      cnt_q        <= {OFF_W{1'b0}};
      rreq_q       <= 1'b0;
      core_out_q   <= {DATA_W{1'b0}};
      flush_pend_q <= 1'b0;
      lru_q        <= {SETS{1'b0}};
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= {WAYS{1'b0}};
      end
      for (int i = 0; i < LINE_WORDS; i++) begin
        lbuf_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      rreq_q       <= rreq_d;
      core_out_q   <= core_out_d;
      flush_pend_q <= flush_pend_d;
      lru_q        <= lru_d;
      valid_q      <= valid_d;
      lbuf_q       <= lbuf_d;
    end
  end

  // Tag and line write into the victim way once the last beat lands.
  always_ff @(posedge clk) begin
    if (fill_we_s) begin
      tag_q[victim_s][idx_s] <= tag_s;
      for (int i = 0; i < LINE_WORDS; i++) begin
        data_q[victim_s][idx_s][i] <= fill_line_s[i];
      end
    end
  end

  // Core stall: in IDLE only when work is pending, released for the DONE cycle.
  always_comb begin
    case (state_q)
      S_IDLE:  core_wait_s = bus.core_req | flush_pend_q | flush;
      S_DONE:  core_wait_s = 1'b0;
      default: core_wait_s = 1'b1;
    endcase
  end

  assign bus.core_out  = core_out_q;
  assign bus.core_wait = core_wait_s;
  assign bus.I_rreq    = rreq_q;
  assign bus.I_addr    = {addr_q[ADDR_W-1:OFF_W+2], cnt_q, 2'b00};
  assign bus.I_type    = `CACHE_WORD;

`ifdef L1CI_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // Saturating lookup counters; flush leaves them untouched.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_LOOKUP) begin
      if (hit_s) begin
        hit_cnt_d = (hit_cnt_q == 32'hFFFF_FFFF) ? hit_cnt_q : hit_cnt_q + 32'd1;
      end else begin
        miss_cnt_d = (miss_cnt_q == 32'hFFFF_FFFF) ? miss_cnt_q : miss_cnt_q + 32'd1;
      end
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_l1c_inst_assoc.sv
// Self-checking bench for l1c_inst_assoc (SETS=64, LINE_WORDS=4, WAYS=2).
module tb_l1c_inst_assoc;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
`ifdef L1CI_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  l1c_inst_assoc_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  l1c_inst_assoc #(
    .ADDR_W(32), .DATA_W(32), .SETS(64), .LINE_WORDS(4), .WAYS(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
`ifdef L1CI_PERF_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic        exp_hit;
    int          stall;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          beats;
  } exp_t;

  int n_vec = 0;
  int n_err = 0;
  exp_t sb_q[$];
  logic [31:0] beat_q[$];
  int stall_cfg = 0;
  int wcnt = 0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  vec_t vecs[14];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: stall_cfg wait cycles before every beat, data derived from the address.
  always @(negedge clk) begin
    if (bus.I_rreq) begin
      if (prev_stall) check("iaddr_hold", bus.I_addr, prev_addr);
      if (wcnt >= stall_cfg) begin
        bus.I_wait = 1'b0;
        wcnt = 0;
      end else begin
        bus.I_wait = 1'b1;
        wcnt++;
      end
      bus.I_out  = mem_word(bus.I_addr);
      prev_stall = bus.I_wait;
      prev_addr  = bus.I_addr;
    end else begin
      bus.I_wait = 1'b0;
      wcnt = 0;
      prev_stall = 1'b0;
    end
  end

  // Log every completed beat address.
  always @(posedge clk) begin
    if (rst_n && bus.I_rreq && !bus.I_wait) beat_q.push_back(bus.I_addr);
  end

  task automatic drain();
    int n = 0;
    while (bus.core_wait && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_idle", 32'(bus.core_wait), 32'd0);
  endtask

  task automatic fetch(input logic [31:0] a, input logic exp_hit, input int stall,
                       input logic [31:0] exp_data, input int flush_at);
    exp_t e;
    int lat;
    bit done;
    e.data  = exp_data;
    e.lat   = exp_hit ? 2 : (6 + 4 * stall);
    e.beats = exp_hit ? 0 : 4;
    sb_q.push_back(e);
    stall_cfg = stall;
    beat_q.delete();
    @(negedge clk);
    bus.core_addr = a;
    bus.core_req  = 1'b1;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      bus.core_req = 1'b0;
      flush = (lat == flush_at);
      if (!bus.core_wait) done = 1'b1;
    end
    flush = 1'b0;
    e = sb_q.pop_front();
    check("done_seen", 32'(done), 32'd1);
    check("core_out", bus.core_out, e.data);
    check("latency", 32'(lat), 32'(e.lat));
    check("beat_count", 32'(beat_q.size()), 32'(e.beats));
    for (int i = 0; i < beat_q.size() && i < 4; i++) begin
      check("beat_addr", beat_q[i], {a[31:4], 2'(i), 2'b00});
    end
    @(negedge clk);
    check("core_out_hold", bus.core_out, e.data);
    check("wait_after_done", 32'(bus.core_wait), (flush_at > 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h0000_0104, 1'b0, 0, 32'hA000_0104};
    vecs[1]  = '{32'h0000_0108, 1'b1, 0, 32'hA000_0108};
    vecs[2]  = '{32'h0000_0504, 1'b0, 0, 32'hA000_0504};
    vecs[3]  = '{32'h0000_0904, 1'b0, 0, 32'hA000_0904};
    vecs[4]  = '{32'h0000_0504, 1'b1, 0, 32'hA000_0504};
    vecs[5]  = '{32'h0000_0104, 1'b0, 0, 32'hA000_0104};
    vecs[6]  = '{32'h0000_0504, 1'b1, 0, 32'hA000_0504};
    vecs[7]  = '{32'h0000_010C, 1'b1, 0, 32'hA000_010C};
    vecs[8]  = '{32'h0000_2000, 1'b0, 3, 32'hA000_2000};
    vecs[9]  = '{32'h0000_200C, 1'b1, 0, 32'hA000_200C};
    vecs[10] = '{32'h0000_0900, 1'b0, 0, 32'hA000_0900};
    vecs[11] = '{32'h0000_0504, 1'b0, 0, 32'hA000_0504};
    vecs[12] = '{32'h0000_0908, 1'b1, 0, 32'hA000_0908};
    vecs[13] = '{32'h0000_0104, 1'b0, 0, 32'hA000_0104};

    bus.core_addr = 32'd0;
    bus.core_req  = 1'b0;
    bus.I_out     = 32'd0;
    bus.I_wait    = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_core_out", bus.core_out, 32'd0);
    check("rst_core_wait", 32'(bus.core_wait), 32'd0);
    check("rst_i_rreq", 32'(bus.I_rreq), 32'd0);
    check("rst_i_addr", bus.I_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven fetches: hits, misses, LRU eviction, stalled refill
    for (int v = 0; v < 14; v++) begin
      drain();
      fetch(vecs[v].addr, vecs[v].exp_hit, vecs[v].stall, vecs[v].exp_data, 0);
    end
`ifdef L1CI_PERF_EN
    check("perf_hits", hit_cnt, 32'd6);
    check("perf_misses", miss_cnt, 32'd8);
`endif

    // Idle flush, then flush pulse during refill of 0x104
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    check("flush_wait", 32'(bus.core_wait), 32'd1);
    drain();
    fetch(32'h0000_0104, 1'b0, 0, 32'hA000_0104, 3);
    @(negedge clk);
    check("flush_runs", 32'(bus.core_wait), 32'd1);
    drain();
    fetch(32'h0000_0104, 1'b0, 0, 32'hA000_0104, 0);

    // Reset during beat 2 of a refill
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    drain();
    stall_cfg = 0;
    beat_q.delete();
    @(negedge clk);
    bus.core_addr = 32'h0000_0104;
    bus.core_req  = 1'b1;
    @(negedge clk);
    bus.core_req  = 1'b0;
    for (int n = 0; n < 20 && beat_q.size() < 2; n++) @(negedge clk);
    check("pre_rst_beats", 32'(beat_q.size()), 32'd2);
    rst_n = 1'b0;
    #1;
    check("midrst_i_rreq", 32'(bus.I_rreq), 32'd0);
    check("midrst_core_wait", 32'(bus.core_wait), 32'd0);
    check("midrst_i_addr", bus.I_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drain();
    fetch(32'h0000_0104, 1'b0, 0, 32'hA000_0104, 0);
`ifdef L1CI_PERF_EN
    check("perf_miss_after_rst", miss_cnt, 32'd1);
    check("perf_hit_after_rst", hit_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
